// File: rtl/register_file.sv
// register_file: 2R1W integer register file, async active-low reset, x0 hardwired to zero
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  WriteEn,
  input  logic [ADDR_WIDTH-1:0] Rs1,
  input  logic [ADDR_WIDTH-1:0] Rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] InputData,
  output logic [DATA_WIDTH-1:0] Rout1,
  output logic [DATA_WIDTH-1:0] Rout2
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  wr_d;
  assign wr_d = WriteEn && (rd != '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_d) begin
      regs_q[rd] <= InputData;
    end
  end
  // reads are unbypassed: a same-cycle write only shows after the edge
  assign Rout1 = (Rs1 == '0) ? '0 : regs_q[Rs1];
  assign Rout2 = (Rs2 == '0) ? '0 : regs_q[Rs2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed plus random checks of register_file against an array model
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        WriteEn;
  logic [4:0]  Rs1, Rs2, rd;
  logic [31:0] InputData;
  logic [31:0] Rout1, Rout2;
  logic [31:0] model [32];
  int          errors = 0;
  int          checks = 0;
  bit          run = 1'b0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .WriteEn(WriteEn), .Rs1(Rs1), .Rs2(Rs2),
    .rd(rd), .InputData(InputData), .Rout1(Rout1), .Rout2(Rout2)
  );

  always #5 clk = ~clk;

  // reference: an array of registers; index 0 is never stored to
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'd0;
    end else if (WriteEn === 1'b1 && rd != 5'd0) begin
      model[rd] <= InputData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("cmp_rout1", Rout1, model[Rs1]);
      chk("cmp_rout2", Rout2, model[Rs2]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1; WriteEn = 1'b0; Rs1 = '0; Rs2 = '0; rd = '0; InputData = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_hold_r1", Rout1, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      Rs1 = 5'(i); Rs2 = 5'(31 - i);
      #1;
      chk("sweep_r1", Rout1, 32'd0);
      chk("sweep_r2", Rout2, 32'd0);
    end
    run = 1'b1;
    step(); rd = 5'd2; InputData = 32'd100; WriteEn = 1'b1; Rs2 = 5'd2;
    #1 chk("t2_before", Rout2, 32'd0);
    step(); WriteEn = 1'b0;
    #1 chk("t2_after", Rout2, 32'd100);
    step(); rd = 5'd0; InputData = 32'd100; WriteEn = 1'b1; Rs1 = 5'd0;
    step(); WriteEn = 1'b0;
    #1 chk("t3_x0", Rout1, 32'd0);
    step(); rd = 5'd5; InputData = 32'hDEADBEEF; Rs1 = 5'd5;
    repeat (3) step();
    chk("t4_noen", Rout1, 32'd0);
    step(); rd = 5'd7; InputData = 32'h12345678; WriteEn = 1'b1;
    step(); WriteEn = 1'b0; Rs1 = 5'd7; Rs2 = 5'd7;
    #1 chk("t5_r1", Rout1, 32'h12345678);
    chk("t5_r2", Rout2, 32'h12345678);
    step(); InputData = 32'hA5A5A5A5; WriteEn = 1'b1;
    #1 chk("t5_old", Rout1, 32'h12345678);
    step(); WriteEn = 1'b0;
    #1 chk("t5_new1", Rout1, 32'hA5A5A5A5);
    chk("t5_new2", Rout2, 32'hA5A5A5A5);
    for (int i = 1; i < 32; i++) begin
      step(); rd = 5'(i); InputData = 32'(i * 3); WriteEn = 1'b1;
    end
    step(); WriteEn = 1'b0; Rs1 = 5'd10; Rs2 = 5'd31;
    #1 chk("t6_r10", Rout1, 32'd30);
    chk("t6_r31", Rout2, 32'd93);
    step(); rd = 5'd9; InputData = 32'h0000FFFF; WriteEn = 1'b1; Rs1 = 5'd9; Rs2 = 5'd30;
    #1 chk("t6_pre9", Rout1, 32'd27);
    chk("t6_pre30", Rout2, 32'd90);
    #1 rst_n = 1'b0;
    #1 chk("t6_rst_r1", Rout1, 32'd0);
    chk("t6_rst_r2", Rout2, 32'd0);
    step(); rst_n = 1'b1; WriteEn = 1'b0;
    #1 chk("t6_wr_ignored", Rout1, 32'd0);
    for (int i = 0; i < 32; i++) begin
      Rs2 = 5'(i);
      #0.1 chk("t6_sweep", Rout2, 32'd0);
    end
    for (int n = 0; n < 600; n++) begin
      step();
      WriteEn = 1'($urandom_range(0, 1));
      rd = 5'($urandom);
      InputData = $urandom;
      Rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      Rs2 = ($urandom_range(0, 7) == 0) ? Rs1 : 5'($urandom);
    end
    step();
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
